// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and forward encodings for the ID-stage hazard controller
package hazard_pkg;

  // Control FSM states: normal issue, waiting on memory, multi-cycle IF/ID flush
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_FLUSH    = 2'd2
  } state_t;

  // Per-operand ID-stage forward select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

endpackage

// File: rtl/hazard_src_cmp.sv
// rtl/hazard_src_cmp.sv - single source-operand match and forward select
module hazard_src_cmp
  import hazard_pkg::*;
#(
  parameter int AW = 5
) (
  input  logic [AW-1:0] i_src,
  input  logic          i_used,
  input  logic [AW-1:0] i_idex_rd,
  input  logic [AW-1:0] i_exmem_rd,
  input  logic [AW-1:0] i_memwb_rd,
  input  logic          i_exmem_reg_write,
  input  logic          i_memwb_reg_write,
  output logic [1:0]    o_fwd,
  output logic          o_m_idex,
  output logic          o_m_exmem,
  output logic          o_m_memwb
);

  logic w_src_nz;

  // Register 0 is hard-wired zero, so it never creates a dependency
  assign w_src_nz  = (i_src != '0);
  assign o_m_idex  = i_used && w_src_nz && (i_idex_rd  == i_src);
  assign o_m_exmem = i_used && w_src_nz && (i_exmem_rd == i_src);
  assign o_m_memwb = i_used && w_src_nz && (i_memwb_rd == i_src);

  // Youngest producer wins: EX/MEM before MEM/WB before the register file
  always_comb begin
    o_fwd = FWD_RF;
    if (i_exmem_reg_write && o_m_exmem) begin
      o_fwd = FWD_EXMEM;
    end else if (i_memwb_reg_write && o_m_memwb) begin
      o_fwd = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - ID-stage hazard controller with memory-wait and flush FSM
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int AW           = 5,
  parameter int NSRC         = 2,
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NSRC*AW-1:0]   i_id_src_addr,
  input  logic [NSRC-1:0]      i_id_src_used,
  input  logic                 i_id_branch,
  input  logic                 i_branch_taken,
  input  logic [AW-1:0]        i_idex_rd,
  input  logic [AW-1:0]        i_exmem_rd,
  input  logic [AW-1:0]        i_memwb_rd,
  input  logic                 i_idex_reg_write,
  input  logic                 i_exmem_reg_write,
  input  logic                 i_memwb_reg_write,
  input  logic                 i_idex_mem_read,
  input  logic                 i_exmem_mem_read,
  input  logic                 i_mem_ready,
  input  logic                 i_clr_stats,
  output logic [2*NSRC-1:0]    o_fwd_sel,
  output logic                 o_pc_write,
  output logic                 o_ifid_write,
  output logic                 o_idex_zero,
  output logic                 o_ifid_flush,
  output logic [CNT_W-1:0]     o_stall_count,
  output logic                 o_mem_timeout
);

  localparam int WW = (MEM_TIMEOUT  > 1) ? $clog2(MEM_TIMEOUT + 1)  : 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX   = WW'(MEM_TIMEOUT);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FW-1:0]   r_flush_cnt;
  logic [FW-1:0]   w_flush_nxt;
  logic [WW-1:0]   r_wait_cnt;
  logic [WW-1:0]   w_wait_nxt;
  logic            w_set_timeout;

  logic [2*NSRC-1:0] w_fwd;
  logic [NSRC-1:0]   w_m_idex;
  logic [NSRC-1:0]   w_m_exmem;
  logic [NSRC-1:0]   w_m_memwb;
  logic              w_load_use;
  logic              w_br_dep;
  logic              w_hold;
  logic              w_br_taken;
  logic              w_pc_write;
  logic              w_ifid_write;
  logic              w_idex_zero;
  logic              w_ifid_flush;

  genvar g;
  generate
    for (g = 0; g < NSRC; g++) begin : g_src
      hazard_src_cmp #(.AW(AW)) u_cmp (
        .i_src             (i_id_src_addr[g*AW +: AW]),
        .i_used            (i_id_src_used[g]),
        .i_idex_rd         (i_idex_rd),
        .i_exmem_rd        (i_exmem_rd),
        .i_memwb_rd        (i_memwb_rd),
        .i_exmem_reg_write (i_exmem_reg_write),
        .i_memwb_reg_write (i_memwb_reg_write),
        .o_fwd             (w_fwd[2*g +: 2]),
        .o_m_idex          (w_m_idex[g]),
        .o_m_exmem         (w_m_exmem[g]),
        .o_m_memwb         (w_m_memwb[g])
      );
    end
  endgenerate

  // Load-use and branch-operand dependencies both hold the front end for a cycle
  assign w_load_use = i_idex_mem_read && (|w_m_idex);
  assign w_br_dep   = i_id_branch && ((i_idex_reg_write && (|w_m_idex)) ||
                                      (i_exmem_mem_read && (|w_m_exmem)));
  assign w_hold     = w_load_use || w_br_dep;
  assign w_br_taken = i_id_branch && i_branch_taken;

  // State, flush counter and wait counter; reset abandons any flush or wait in progress
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
      r_wait_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_wait_cnt  <= w_wait_nxt;
    end
  end

  // Next-state and pipeline-control outputs; MEM_WAIT with memory ready behaves as RUN
  always_comb begin
    w_state_nxt   = r_state;
    w_flush_nxt   = r_flush_cnt;
    w_wait_nxt    = r_wait_cnt;
    w_set_timeout = 1'b0;
    w_pc_write    = 1'b1;
    w_ifid_write  = 1'b1;
    w_idex_zero   = 1'b0;
    w_ifid_flush  = 1'b0;

    case (r_state)
      ST_FLUSH: begin
        // A memory stall freezes the flush count so no flush cycle is lost
        if (i_mem_ready) begin
          if (r_flush_cnt <= FW'(1)) begin
            w_state_nxt = ST_RUN;
            w_flush_nxt = '0;
          end else begin
            w_flush_nxt = r_flush_cnt - FW'(1);
          end
        end
      end
      default: begin
        if (!i_mem_ready) begin
          w_state_nxt = ST_MEM_WAIT;
          if (r_state == ST_RUN) begin
            w_wait_nxt = WW'(1);
          end else if (r_wait_cnt < WAIT_MAX) begin
            w_wait_nxt = r_wait_cnt + WW'(1);
          end
          w_set_timeout = (w_wait_nxt == WAIT_MAX);
        end else begin
          w_wait_nxt = '0;
          if (w_br_taken && !w_hold && (FLUSH_CYCLES > 1)) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = FLUSH_LOAD;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
    endcase

    if (!i_mem_ready || w_hold) begin
      w_pc_write   = 1'b0;
      w_ifid_write = 1'b0;
      w_idex_zero  = 1'b1;
    end else if (r_state == ST_FLUSH) begin
      w_ifid_flush = 1'b1;
    end else if (w_br_taken) begin
      w_ifid_flush = 1'b1;
    end
  end

  // Reset forces a full stall on the outputs even before the first clock edge
  assign o_pc_write   = i_rst_n ? w_pc_write   : 1'b0;
  assign o_ifid_write = i_rst_n ? w_ifid_write : 1'b0;
  assign o_idex_zero  = i_rst_n ? w_idex_zero  : 1'b1;
  assign o_ifid_flush = i_rst_n ? w_ifid_flush : 1'b0;
  assign o_fwd_sel    = i_rst_n ? w_fwd        : '0;

  // Stall statistics: saturating stall counter and sticky timeout, clear wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_count <= '0;
      o_mem_timeout <= 1'b0;
    end else if (i_clr_stats) begin
      o_stall_count <= '0;
      o_mem_timeout <= 1'b0;
    end else begin
      if (!w_pc_write && (o_stall_count != '1)) begin
        o_stall_count <= o_stall_count + CNT_W'(1);
      end
      if (w_set_timeout) begin
        o_mem_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - self-checking bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int AW    = 5;
  localparam int NSRC  = 2;
  localparam int FC    = 3;
  localparam int MT    = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic                clk;
  logic                rst_n;
  logic [NSRC*AW-1:0]  src_addr;
  logic [NSRC-1:0]     src_used;
  logic                id_branch, branch_taken;
  logic [AW-1:0]       idex_rd, exmem_rd, memwb_rd;
  logic                idex_reg_write, exmem_reg_write, memwb_reg_write;
  logic                idex_mem_read, exmem_mem_read;
  logic                mem_ready, clr_stats;
  logic [2*NSRC-1:0]   fwd_sel;
  logic                pc_write, ifid_write, idex_zero, ifid_flush;
  logic [CNT_W-1:0]    stall_count;
  logic                mem_timeout;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_flush_rem;
  int   m_wait;
  int   m_to;
  int   m_cnt;
  logic [2*NSRC-1:0] e_fwd;
  logic e_pc, e_ifw, e_zero, e_flush, e_hold;

  pipeline_hazard_ctrl #(
    .AW(AW), .NSRC(NSRC), .FLUSH_CYCLES(FC), .MEM_TIMEOUT(MT), .CNT_W(CNT_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_id_src_addr     (src_addr),
    .i_id_src_used     (src_used),
    .i_id_branch       (id_branch),
    .i_branch_taken    (branch_taken),
    .i_idex_rd         (idex_rd),
    .i_exmem_rd        (exmem_rd),
    .i_memwb_rd        (memwb_rd),
    .i_idex_reg_write  (idex_reg_write),
    .i_exmem_reg_write (exmem_reg_write),
    .i_memwb_reg_write (memwb_reg_write),
    .i_idex_mem_read   (idex_mem_read),
    .i_exmem_mem_read  (exmem_mem_read),
    .i_mem_ready       (mem_ready),
    .i_clr_stats       (clr_stats),
    .o_fwd_sel         (fwd_sel),
    .o_pc_write        (pc_write),
    .o_ifid_write      (ifid_write),
    .o_idex_zero       (idex_zero),
    .o_ifid_flush      (ifid_flush),
    .o_stall_count     (stall_count),
    .o_mem_timeout     (mem_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    src_addr = '0; src_used = '0; id_branch = 0; branch_taken = 0;
    idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
    idex_reg_write = 0; exmem_reg_write = 0; memwb_reg_write = 0;
    idex_mem_read = 0; exmem_mem_read = 0; mem_ready = 1; clr_stats = 0;
  endtask

  task automatic model_reset();
    m_flush_rem = 0; m_wait = 0; m_to = 0; m_cnt = 0;
  endtask

  // Expected combinational outputs straight from the dependency rules
  task automatic expect_now();
    logic [AW-1:0] s;
    logic any_i, any_e, mi, me, mw, stall;
    any_i = 0; any_e = 0; e_fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      s  = src_addr[i*AW +: AW];
      mi = src_used[i] && (s != 0) && (idex_rd  == s);
      me = src_used[i] && (s != 0) && (exmem_rd == s);
      mw = src_used[i] && (s != 0) && (memwb_rd == s);
      any_i = any_i | mi;
      any_e = any_e | me;
      if (exmem_reg_write && me)      e_fwd[2*i +: 2] = 2'b10;
      else if (memwb_reg_write && mw) e_fwd[2*i +: 2] = 2'b01;
    end
    e_hold = (idex_mem_read && any_i) ||
             (id_branch && ((idex_reg_write && any_i) || (exmem_mem_read && any_e)));
    stall = !mem_ready || e_hold;
    e_pc = !stall; e_ifw = !stall; e_zero = stall;
    e_flush = !stall && ((m_flush_rem > 0) || (id_branch && branch_taken));
  endtask

  // Advance the model across one clock edge
  task automatic model_edge();
    int tset;
    tset = 0;
    expect_now();
    if (m_flush_rem > 0) begin
      if (mem_ready) m_flush_rem--;
    end else if (!mem_ready) begin
      m_wait = (m_wait == 0) ? 1 : ((m_wait < MT) ? m_wait + 1 : MT);
      tset = (m_wait >= MT);
    end else begin
      m_wait = 0;
      if (id_branch && branch_taken && !e_hold && FC > 1) m_flush_rem = FC - 1;
    end
    if (clr_stats) begin
      m_cnt = 0; m_to = 0;
    end else begin
      if (!e_pc && m_cnt < CMAX) m_cnt++;
      if (tset != 0) m_to = 1;
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk);
    expect_now();
    chk({tag, ".fwd"},   fwd_sel,     e_fwd);
    chk({tag, ".pc"},    pc_write,    e_pc);
    chk({tag, ".ifw"},   ifid_write,  e_ifw);
    chk({tag, ".zero"},  idex_zero,   e_zero);
    chk({tag, ".flush"}, ifid_flush,  e_flush);
    chk({tag, ".cnt"},   stall_count, m_cnt);
    chk({tag, ".to"},    mem_timeout, m_to);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".pc"},    pc_write,    0);
    chk({tag, ".ifw"},   ifid_write,  0);
    chk({tag, ".zero"},  idex_zero,   1);
    chk({tag, ".flush"}, ifid_flush,  0);
    chk({tag, ".fwd"},   fwd_sel,     0);
    chk({tag, ".cnt"},   stall_count, 0);
    chk({tag, ".to"},    mem_timeout, 0);
  endtask

  initial begin
    idle();
    rst_n = 0;
    model_reset();
    exmem_rd = 7; exmem_reg_write = 1; src_addr[AW-1:0] = 7; src_used = 2'b01;
    #3;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    tick("idle");

    // load-use on operand 0
    idex_mem_read = 1; idex_rd = 5; src_addr[AW-1:0] = 5; src_used = 2'b01;
    tick("load_use");
    idle();
    tick("after_load_use");
    chk("load_use_count", stall_count, 1);

    // register 0 and unused operand never stall
    idex_mem_read = 1; idex_rd = 0; src_used = 2'b01;
    tick("r0_load");
    idex_rd = 5; src_addr[2*AW-1:AW] = 5; src_used = 2'b01;
    tick("unused_src1");

    // forward priority
    idle();
    exmem_rd = 7; memwb_rd = 7; exmem_reg_write = 1; memwb_reg_write = 1;
    src_addr[AW-1:0] = 7; src_used = 2'b01;
    tick("fwd_exmem");
    chk("fwd_exmem_val", fwd_sel[1:0], 2'b10);
    exmem_reg_write = 0;
    tick("fwd_memwb");

    // taken branch: three flush cycles
    idle();
    id_branch = 1; branch_taken = 1;
    tick("br0");
    idle();
    tick("br1");
    tick("br2");
    tick("br_done");
    chk("br_done_flush", ifid_flush, 0);

    // taken branch with a memory stall in the second flush cycle
    id_branch = 1; branch_taken = 1;
    tick("brm0");
    idle();
    mem_ready = 0;
    tick("brm_stall");
    mem_ready = 1;
    tick("brm1");
    tick("brm2");
    tick("brm_done");

    // memory timeout after four wait cycles, then clear
    clr_stats = 1;
    tick("clr0");
    clr_stats = 0;
    mem_ready = 0;
    for (int i = 0; i < 6; i++) tick("wait");
    mem_ready = 1;
    tick("wait_end");
    chk("timeout_cnt6", stall_count, 6);
    chk("timeout_set", mem_timeout, 1);
    clr_stats = 1;
    tick("clr1");
    clr_stats = 0;
    chk("clr_cnt", stall_count, 0);
    chk("clr_to", mem_timeout, 0);

    // stall counter saturation
    mem_ready = 0;
    for (int i = 0; i < CMAX + 3; i++) tick("sat");
    mem_ready = 1;
    tick("sat_end");
    chk("sat_val", stall_count, CMAX);

    // async reset in the middle of a flush
    clr_stats = 1;
    tick("clr2");
    idle();
    id_branch = 1; branch_taken = 1;
    tick("brr0");
    idle();
    tick("brr1");
    exmem_rd = 7; exmem_reg_write = 1; src_addr[AW-1:0] = 7; src_used = 2'b01;
    rst_n = 0;
    model_reset();
    #1;
    chk_reset_outputs("mid_flush_reset");
    @(posedge clk); #1;
    rst_n = 1;
    idle();
    tick("post_reset");
    chk("post_reset_flush", ifid_flush, 0);

    // randomized traffic against the model
    for (int n = 0; n < 500; n++) begin
      src_addr        = '0;
      for (int i = 0; i < NSRC; i++) src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
      src_used        = NSRC'($urandom);
      idex_rd         = AW'($urandom_range(0, 3));
      exmem_rd        = AW'($urandom_range(0, 3));
      memwb_rd        = AW'($urandom_range(0, 3));
      idex_reg_write  = 1'($urandom);
      exmem_reg_write = 1'($urandom);
      memwb_reg_write = 1'($urandom);
      idex_mem_read   = ($urandom_range(0, 3) == 0);
      exmem_mem_read  = ($urandom_range(0, 3) == 0);
      id_branch       = ($urandom_range(0, 2) == 0);
      branch_taken    = 1'($urandom);
      mem_ready       = ($urandom_range(0, 5) != 0);
      clr_stats       = ($urandom_range(0, 40) == 0);
      tick("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
